// File: rtl/bloco_controle_pkg.sv
// bloco_controle_pkg: shared states, op codes, mux selects and step control-word decode
// Exports state_t, step_t and step_word(), which maps an FSM state to the
// control word it drives toward bloco_operativo.
package bloco_controle_pkg;
    typedef enum logic [3:0] {IDLE, LOAD, P1, P2, P3, P4, L1, L2, Q1, Q2, DONE, ERR} state_t;
    typedef enum logic [1:0] {ST_NONE, ST_S, ST_X, ST_H} strobe_t;
    localparam logic [1:0] OP_POLY = 2'b00;
    localparam logic [1:0] OP_LIN  = 2'b01;
    localparam logic [1:0] OP_SQR  = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;
    localparam logic [1:0] SEL_A   = 2'b00;
    localparam logic [1:0] SEL_B   = 2'b10;
    localparam logic [1:0] SEL_C   = 2'b11;
    // m1 and m2 place the m0 path and X at swapped codes; S and H share codes
    localparam logic [1:0] M1_SEL_M0 = 2'b00;
    localparam logic [1:0] M1_SEL_X  = 2'b01;
    localparam logic [1:0] M2_SEL_X  = 2'b00;
    localparam logic [1:0] M2_SEL_M0 = 2'b01;
    localparam logic [1:0] SEL_S   = 2'b10;
    localparam logic [1:0] SEL_H   = 2'b11;
    typedef struct packed {
        logic       mul;
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
        strobe_t    strobe;
    } step_t;
    function automatic step_t step_word(state_t s);
        step_t w;
        w = '{mul: 1'b0, m0: SEL_A, m1: M1_SEL_M0, m2: M2_SEL_X, strobe: ST_NONE};
        case (s)
            LOAD:   w.strobe = ST_X;
            P1, Q1: begin w.mul = 1'b1; w.strobe = ST_S; end
            L1:     begin w.mul = 1'b1; w.strobe = ST_H; end
            P2:     begin w.m0 = SEL_B; w.m2 = SEL_S; w.strobe = ST_S; end
            P3, Q2: begin w.mul = 1'b1; w.m1 = M1_SEL_X; w.m2 = SEL_S; w.strobe = ST_S; end
            P4:     begin w.m0 = SEL_C; w.m2 = SEL_S; w.strobe = ST_S; end
            L2:     begin w.m0 = SEL_B; w.m2 = SEL_H; w.strobe = ST_S; end
            default: ;
        endcase
        return w;
    endfunction
endpackage

// File: rtl/bloco_controle_if.sv
// bloco_controle_if: request/status and control-word bundle between requester and controller
// start/op: request; ready/done/err: status; h, ls/lx/lh, m0/m1/m2: datapath control word.
interface bloco_controle_if;
    logic       start;
    logic [1:0] op;
    logic       ready;
    logic       done;
    logic       err;
    logic       h;
    logic       ls;
    logic       lx;
    logic       lh;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    modport master (output start, op, input ready, done, err, h, ls, lx, lh, m0, m1, m2);
    modport slave (input start, op, output ready, done, err, h, ls, lx, lh, m0, m1, m2);
endinterface

// File: rtl/bloco_controle_contador_espera.sv
// contador_espera: step-hold counter, last marks the final cycle of an ALU step
// clock/reset: clocking, async active-high reset; clr: restart at 0; last: count == ALU_WAIT.
module contador_espera #(
    parameter int ALU_WAIT = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    output logic last
);
    localparam int W = ALU_WAIT > 0 ? $clog2(ALU_WAIT + 1) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    assign last  = cnt_q == W'(ALU_WAIT);
    assign cnt_d = clr ? '0 : last ? cnt_q : cnt_q + 1'b1;
    always_ff @(posedge clock or posedge reset)
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/bloco_controle.sv
// bloco_controle: Moore control FSM sequencing bloco_operativo through three fixed formulas
// clock/reset: clocking, async active-high reset; bus (slave): start/op in,
// ready/done/err status and h, ls/lx/lh, m0/m1/m2 control word out.
module bloco_controle
    import bloco_controle_pkg::*;
#(
    parameter int   ALU_WAIT = 0,
    parameter logic H_MUL    = 1'b1
) (
    input logic             clock,
    input logic             reset,
    bloco_controle_if.slave bus
);
    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;
    logic       last, in_step;
    step_t      w;
    assign in_step = state_q inside {P1, P2, P3, P4, L1, L2, Q1, Q2};
    // counter sits at 0 outside steps and restarts on a step's last cycle, so every step enters at 0
    contador_espera #(.ALU_WAIT(ALU_WAIT)) u_espera (
        .clock(clock),
        .reset(reset),
        .clr  (~in_step | last),
        .last (last)
    );
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_POLY;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = bus.op == OP_RSV ? ERR : LOAD;
                op_d    = bus.op == OP_RSV ? op_q : bus.op;
            end
            LOAD:           state_d = op_q == OP_POLY ? P1 : op_q == OP_LIN ? L1 : Q1;
            P1:             state_d = last ? P2 : P1;
            P2:             state_d = last ? P3 : P2;
            P3:             state_d = last ? P4 : P3;
            L1:             state_d = last ? L2 : L1;
            Q1:             state_d = last ? Q2 : Q1;
            P4, L2, Q2:     state_d = last ? DONE : state_q;
            default:        state_d = IDLE;
        endcase
    end
    always_comb w = step_word(state_q);
    assign bus.ready = state_q == IDLE;
    assign bus.done  = state_q == DONE;
    assign bus.err   = state_q == ERR;
    assign bus.h     = w.mul ? H_MUL : ~H_MUL;
    assign bus.m0    = w.m0;
    assign bus.m1    = w.m1;
    assign bus.m2    = w.m2;
    // LOAD is a single fixed cycle; ALU steps strobe only once the operands have settled
    assign bus.lx    = w.strobe == ST_X;
    assign bus.ls    = w.strobe == ST_S && last;
    assign bus.lh    = w.strobe == ST_H && last;
endmodule

// File: tb/tb_bloco_controle.sv
// tb_bloco_controle: directed bench driving two controllers (ALU_WAIT 0 and 2) with a datapath model
module tb_bloco_controle;
    logic clk, rst;
    logic signed [15:0] av, bv, cv;
    logic signed [7:0]  xv;
    logic signed [15:0] s0 = 0, x0 = 0, h0 = 0, s2 = 0, x2 = 0, h2 = 0;
    logic [12:0] p0, p2;
    logic [31:0] rdy_m, done_m, err_m, h_m, ls_m, lx_m, lh_m, m1_m;
    int done_at, n_done, excl;
    int n_checks = 0, n_errors = 0;

    bloco_controle_if ifc0 ();
    bloco_controle_if ifc2 ();

    bloco_controle #(.ALU_WAIT(0)) u_dut0 (.clock(clk), .reset(rst), .bus(ifc0.slave));
    bloco_controle #(.ALU_WAIT(2)) u_dut2 (.clock(clk), .reset(rst), .bus(ifc2.slave));

    assign p0 = {ifc0.ready, ifc0.done, ifc0.err, ifc0.h, ifc0.ls, ifc0.lx, ifc0.lh, ifc0.m0, ifc0.m1, ifc0.m2};
    assign p2 = {ifc2.ready, ifc2.done, ifc2.err, ifc2.h, ifc2.ls, ifc2.lx, ifc2.lh, ifc2.m0, ifc2.m1, ifc2.m2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [15:0] ula(input logic h, input logic [1:0] m0, m1, m2,
                                               input logic signed [15:0] xr, sr, hr);
        logic signed [15:0] v0, i1, i2;
        v0 = m0 == 2'b10 ? bv : m0 == 2'b11 ? cv : av;
        i1 = m1 == 2'b00 ? v0 : m1 == 2'b01 ? xr : m1 == 2'b10 ? sr : hr;
        i2 = m2 == 2'b00 ? xr : m2 == 2'b01 ? v0 : m2 == 2'b10 ? sr : hr;
        return h ? i1 * i2 : i1 + i2;
    endfunction

    always @(posedge clk) begin
        if (ifc0.lx) x0 <= {{8{xv[7]}}, xv};
        if (ifc0.ls) s0 <= ula(ifc0.h, ifc0.m0, ifc0.m1, ifc0.m2, x0, s0, h0);
        if (ifc0.lh) h0 <= ula(ifc0.h, ifc0.m0, ifc0.m1, ifc0.m2, x0, s0, h0);
        if (ifc2.lx) x2 <= {{8{xv[7]}}, xv};
        if (ifc2.ls) s2 <= ula(ifc2.h, ifc2.m0, ifc2.m1, ifc2.m2, x2, s2, h2);
        if (ifc2.lh) h2 <= ula(ifc2.h, ifc2.m0, ifc2.m1, ifc2.m2, x2, s2, h2);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic drive(input int d, input logic s, input logic [1:0] o);
        if (d == 0) begin ifc0.start = s; ifc0.op = o; end
        else begin ifc2.start = s; ifc2.op = o; end
    endtask

    task automatic run(input int d, input logic [1:0] o, input int restart, input int rst_at, input int ncyc);
        logic [12:0] p;
        {rdy_m, done_m, err_m, h_m, ls_m, lx_m, lh_m, m1_m} = '0;
        done_at = 0;
        n_done  = 0;
        excl    = 0;
        @(negedge clk);
        drive(d, 1'b1, o);
        @(posedge clk);
        #1 drive(d, 1'b0, o);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            p = d == 0 ? p0 : p2;
            rdy_m[k] = p[12]; done_m[k] = p[11]; err_m[k] = p[10]; h_m[k] = p[9];
            ls_m[k] = p[8]; lx_m[k] = p[7]; lh_m[k] = p[6]; m1_m[k] = |p[3:2];
            if (p[11]) begin
                n_done++;
                if (done_at == 0) done_at = k;
            end
            if (int'(p[8]) + int'(p[7]) + int'(p[6]) > 1) excl++;
            if (k == restart) drive(d, 1'b1, 2'b01);
            if (k == restart + 1) drive(d, 1'b0, o);
            if (k == rst_at) begin
                rst = 1'b1;
                #1 chk("rst_mid_outs", int'(p0), 32'h1000);
                #1 rst = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 2'b00);
        drive(2, 1'b0, 2'b00);
        av = 2; bv = 3; cv = 4; xv = 5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs_w0", int'(p0), 32'h1000);
        chk("reset_outs_w2", int'(p2), 32'h1000);
        rst = 1'b0;

        run(0, 2'b00, 0, 0, 10);
        chk("poly_done_at", done_at, 6);
        chk("poly_result", int'(s0), 69);
        chk("poly_ready", int'(rdy_m), 32'h780);
        chk("poly_ls", int'(ls_m), 32'h3C);
        chk("poly_lx", int'(lx_m), 32'h02);
        chk("poly_n_done", n_done, 1);
        chk("poly_excl", excl, 0);

        av = 3; bv = 10; xv = -4;
        run(0, 2'b01, 0, 0, 8);
        chk("lin_done_at", done_at, 4);
        chk("lin_result", int'(s0), -2);
        chk("lin_lh", int'(lh_m), 32'h04);
        chk("lin_ls", int'(ls_m), 32'h08);

        av = 7; xv = 3;
        run(2, 2'b10, 0, 0, 12);
        chk("sqr_w2_done_at", done_at, 8);
        chk("sqr_w2_result", int'(s2), 63);
        chk("sqr_w2_ls", int'(ls_m), 32'h90);
        chk("sqr_w2_h", int'(h_m), 32'hFC);
        chk("sqr_w2_m1", int'(m1_m), 32'hE0);

        run(0, 2'b11, 0, 0, 10);
        chk("rsv_err", int'(err_m), 32'h02);
        chk("rsv_strobes", int'(ls_m | lx_m | lh_m), 0);
        chk("rsv_ready", int'(rdy_m), 32'h7FC);
        chk("rsv_s_kept", int'(s0), -2);

        av = 2; bv = 3; cv = 4; xv = 5;
        run(0, 2'b00, 3, 0, 10);
        chk("restart_done_at", done_at, 6);
        chk("restart_n_done", n_done, 1);
        chk("restart_result", int'(s0), 69);
        chk("restart_excl", excl, 0);

        run(0, 2'b00, 0, 4, 10);
        chk("rst_n_done", n_done, 0);
        chk("rst_partial_s", int'(s0), 13);

        av = 3; bv = 10; xv = -4;
        run(0, 2'b01, 0, 0, 8);
        chk("after_rst_done_at", done_at, 4);
        chk("after_rst_result", int'(s0), -2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
